// File: rtl/memoryb_reader_pkg.sv
// rtl/memoryb_reader_pkg.sv - shared defaults and FSM encoding for the memoryB read-back engine
package memb_pkg;

   localparam int DW_DEF    = 8;
   localparam int AW_DEF    = 2;
   localparam int DEPTH_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_PRESENT = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/memoryb_reader_if.sv
// rtl/memoryb_reader_if.sv - control, memoryB bus and result stream of the read-back engine
interface memoryb_reader_if
   import memb_pkg::*;
   #(
      parameter int DW = DW_DEF,
      parameter int AW = AW_DEF
   );

   logic          Start;
   logic          Busy;
   logic          Done;
   logic          REB;
   logic [AW-1:0] AddrB;
   logic [DW-1:0] DOutB;
   logic [DW-1:0] DataOut;
   logic          DataValid;
   logic          DataReady;
   logic [AW-1:0] Index;

   modport master (
      input  Start, DOutB, DataReady,
      output Busy, Done, REB, AddrB, DataOut, DataValid, Index
   );

   modport slave (
      output Start, DOutB, DataReady,
      input  Busy, Done, REB, AddrB, DataOut, DataValid, Index
   );

endinterface

// File: rtl/memoryb_reader_read_counter.sv
// rtl/memoryb_reader_read_counter.sv - address counter with clear, increment and terminal flag
module read_counter
   import memb_pkg::*;
   #(
      parameter int AW    = AW_DEF,
      parameter int DEPTH = DEPTH_DEF
   ) (
      input  logic          clk,
      input  logic          reset,
      input  logic          clr,
      input  logic          inc,
      output logic [AW-1:0] cnt,
      output logic          term
   );

   logic [AW-1:0] cnt_q;
   logic [AW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign term = (cnt_q == AW'(DEPTH - 1));

endmodule

// File: rtl/memoryb_reader.sv
// rtl/memoryb_reader.sv - walks memoryB once per Start and streams each word out with valid/ready
module memoryb_reader
   import memb_pkg::*;
   #(
      parameter int DW    = DW_DEF,
      parameter int AW    = AW_DEF,
      parameter int DEPTH = DEPTH_DEF
   ) (
      input  logic             clk,
      input  logic             reset,
      memoryb_reader_if.master bus
   );

   state_t        state_q;
   state_t        state_d;
   logic [DW-1:0] data_q;
   logic [DW-1:0] data_d;
   logic [AW-1:0] index_q;
   logic [AW-1:0] index_d;
   logic          cnt_clr;
   logic          cnt_inc;
   logic [AW-1:0] cnt;
   logic          cnt_term;

   read_counter #(.AW(AW), .DEPTH(DEPTH)) u_read_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .cnt   (cnt),
      .term  (cnt_term)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      index_d = index_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.Start) begin
               cnt_clr = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         // memoryB answers one cycle after REB, so the word is captured here
         ST_WAIT: begin
            data_d  = bus.DOutB;
            index_d = cnt;
            state_d = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (bus.DataReady) begin
               if (cnt_term) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_inc = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         index_q <= index_d;
      end
   end

   assign bus.Busy      = (state_q != ST_IDLE);
   assign bus.Done      = (state_q == ST_DONE);
   assign bus.REB       = (state_q == ST_ISSUE);
   assign bus.DataValid = (state_q == ST_PRESENT);
   assign bus.AddrB     = cnt;
   assign bus.DataOut   = data_q;
   assign bus.Index     = index_q;

endmodule

// File: tb/tb_memoryb_reader.sv
// tb/tb_memoryb_reader.sv - randomized bench for memoryb_reader against a memoryB model and pass-level reference
module tb_memoryb_reader;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   logic [7:0] mem [4];
   logic [7:0] rd_q;

   memoryb_reader_if #(.DW(8), .AW(2)) bus ();

   memoryb_reader #(.DW(8), .AW(2), .DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memoryB: synchronous read, one cycle latency
   always @(posedge clk) begin
      if (bus.REB) rd_q <= mem[bus.AddrB];
   end
   assign bus.DOutB = rd_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},  32'(bus.Busy), 0);
      check({tag, "_done"},  32'(bus.Done), 0);
      check({tag, "_reb"},   32'(bus.REB), 0);
      check({tag, "_addr"},  32'(bus.AddrB), 0);
      check({tag, "_valid"}, 32'(bus.DataValid), 0);
      check({tag, "_data"},  32'(bus.DataOut), 0);
      check({tag, "_index"}, 32'(bus.Index), 0);
   endtask

   // bp_mode: 0 always ready, 1 stall word 1 for 5 cycles, 2 random ready
   task automatic do_pass(input int bp_mode, input bit start_again, input bit start_in_done,
                          input bit reset_mid);
      int         cyc = 1;
      int         acc_n = 0;
      int         reb_n = 0;
      int         done_n = 0;
      int         done_cyc = 0;
      int         stall = 0;
      bit         hold = 0;
      bit         prev_acc = 0;
      bit         finished = 0;
      logic [7:0] hd = '0;
      logic [1:0] hi = '0;
      bus.Start = 1'b1;
      @(posedge clk); #1;
      bus.Start = 1'b0;
      while (!finished && cyc < 200) begin
         check("busy", 32'(bus.Busy), 1);
         if (cyc == 1) check("issue_t1", 32'(bus.REB), 1);
         if (cyc == 3) check("valid_t3", 32'(bus.DataValid), 1);
         if (hold) begin
            check("hold_valid", 32'(bus.DataValid), 1);
            check("hold_data",  32'(bus.DataOut), 32'(hd));
            check("hold_index", 32'(bus.Index), 32'(hi));
            check("hold_noreb", 32'(bus.REB), 0);
         end
         if (prev_acc) check("valid_drop", 32'(bus.DataValid), 0);
         if (bus.REB) begin
            check("reb_addr", 32'(bus.AddrB), 32'(reb_n));
            reb_n++;
         end
         if (reset_mid && bus.DataValid && bus.Index == 2'd2) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check_idle_outputs("mid_reset");
            return;
         end
         case (bp_mode)
            0:       bus.DataReady = 1'b1;
            1: begin
               bus.DataReady = !(bus.DataValid && bus.Index == 2'd1 && stall < 5);
               if (!bus.DataReady) stall++;
            end
            default: bus.DataReady = 1'($urandom_range(0, 1));
         endcase
         bus.Start = start_again && (cyc == 4);
         if (bus.Done) begin
            done_n++;
            done_cyc = cyc;
            finished = 1'b1;
            check("done_noreb", 32'(bus.REB), 0);
            if (start_in_done) bus.Start = 1'b1;
         end
         hold = bus.DataValid && !bus.DataReady;
         if (hold) begin
            hd = bus.DataOut;
            hi = bus.Index;
         end
         prev_acc = bus.DataValid && bus.DataReady;
         if (prev_acc) begin
            if (acc_n < 4) begin
               check("word",  32'(bus.DataOut), 32'(mem[acc_n]));
               check("index", 32'(bus.Index), 32'(acc_n));
            end else begin
               check("extra_word", 32'(acc_n), 3);
            end
            acc_n++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.Start = 1'b0;
      check("done_seen", 32'(done_n), 1);
      check("words", 32'(acc_n), 4);
      check("reb_count", 32'(reb_n), 4);
      if (bp_mode == 0) check("done_cycle", 32'(done_cyc), 13);
      if (bp_mode == 1) check("stall_cycles", 32'(stall), 5);
      check("post_busy",  32'(bus.Busy), 0);
      check("post_done",  32'(bus.Done), 0);
      check("post_reb",   32'(bus.REB), 0);
      check("post_valid", 32'(bus.DataValid), 0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset         = 1'b1;
      bus.Start     = 1'b0;
      bus.DataReady = 1'b0;
      rd_q          = '0;
      mem[0] = 8'h05; mem[1] = 8'h0A; mem[2] = 8'h03; mem[3] = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      do_pass(0, 1'b0, 1'b0, 1'b0);
      do_pass(1, 1'b0, 1'b0, 1'b0);
      do_pass(0, 1'b1, 1'b0, 1'b0);
      do_pass(0, 1'b0, 1'b0, 1'b1);
      do_pass(0, 1'b0, 1'b1, 1'b0);
      do_pass(0, 1'b0, 1'b0, 1'b0);

      for (int p = 0; p < 20; p++) begin
         for (int k = 0; k < 4; k++) mem[k] = 8'($urandom);
         do_pass(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
